// File: rtl/conv3x3_top.sv
// conv3x3_top
//   Latches a 4x4 unsigned 8-bit image and a 3x3 unsigned 8-bit filter, then
//   computes the 2x2 valid convolution (filter rotated 180 degrees, mod 256)
//   on three independent engines in sequence, and streams the twelve results
//   one per cycle on the display port.
//
// Ports
//   clk                    in   1  clock, rising edge
//   reset                  in   1  synchronous active-high reset
//   run                    in   1  start request, sampled only in IDLE
//   a11..a44               in   8  image pixels (row, column)
//   b11..b33               in   8  filter taps (row, column)
//   display_result         out  8  result being displayed (0 outside OUT/DONE)
//   display_current_state  out  3  FSM state encoding
//
// Result order on the display: single c11,c12,c21,c22, sys3 c11..c22,
// sys2 c11..c22.

module conv3x3_top (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] a11, a12, a13, a14,
  input  logic [7:0] a21, a22, a23, a24,
  input  logic [7:0] a31, a32, a33, a34,
  input  logic [7:0] a41, a42, a43, a44,
  input  logic [7:0] b11, b12, b13,
  input  logic [7:0] b21, b22, b23,
  input  logic [7:0] b31, b32, b33,
  output logic [7:0] display_result,
  output logic [2:0] display_current_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SINGLE = 3'd2,
    S_SYS3   = 3'd3,
    S_SYS2   = 3'd4,
    S_OUT    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Low byte of an 8x8 product depends only on the operands, so an 8-bit
  // multiply gives the mod-256 product directly.
  function automatic logic [7:0] f_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] v_p;
    v_p = a * b;
    return v_p;
  endfunction

  // Flat image index for zero-based (row, col).
  function automatic logic [3:0] f_aidx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Flat filter index of the 180-degree rotated tap for zero-based (p, q).
  function automatic logic [3:0] f_bidx(input logic [1:0] p, input logic [1:0] q);
    return (4'd2 - {2'b00, p}) * 4'd3 + (4'd2 - {2'b00, q});
  endfunction

  state_t     r_state, w_next;
  logic [5:0] r_phase;
  logic [3:0] r_idx;
  logic [7:0] r_disp;

  logic [7:0] w_img_in [0:15];
  logic [7:0] w_flt_in [0:8];
  logic [7:0] r_img    [0:15];
  logic [7:0] r_flt    [0:8];

  assign w_img_in = '{a11, a12, a13, a14, a21, a22, a23, a24,
                      a31, a32, a33, a34, a41, a42, a43, a44};
  assign w_flt_in = '{b11, b12, b13, b21, b22, b23, b31, b32, b33};

  assign display_result        = r_disp;
  assign display_current_state = r_state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= 6'd0;
    end else begin
      r_state <= w_next;
      r_phase <= (w_next != r_state) ? 6'd0 : r_phase + 6'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_LOAD;
      S_LOAD:   w_next = S_SINGLE;
      S_SINGLE: if (r_phase == 6'd47) w_next = S_SYS3;
      S_SYS3:   if (r_phase == 6'd23) w_next = S_SYS2;
      S_SYS2:   if (r_phase == 6'd23) w_next = S_OUT;
      S_OUT:    if (r_idx == 4'd11) w_next = S_DONE;
      S_DONE:   w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // ---------------- operand latch ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) r_img[k] <= 8'd0;
      for (int k = 0; k < 9; k++)  r_flt[k] <= 8'd0;
    end else if (r_state == S_LOAD) begin
      for (int k = 0; k < 16; k++) r_img[k] <= w_img_in[k];
      for (int k = 0; k < 9; k++)  r_flt[k] <= w_flt_in[k];
    end
  end

  // ---------------- SINGLE: one MAC, 36 products ----------------
  logic [1:0] r_s_out, r_s_p, r_s_q;
  logic [7:0] r_s_acc;
  logic       r_s_done;
  logic [7:0] r_s_res [0:3];
  logic [1:0] w_s_row, w_s_col;
  logic [7:0] w_s_sum;
  logic       w_s_en;

  assign w_s_row = {1'b0, r_s_out[1]} + r_s_p;
  assign w_s_col = {1'b0, r_s_out[0]} + r_s_q;
  assign w_s_sum = r_s_acc + f_mul8(r_img[f_aidx(w_s_row, w_s_col)], r_flt[f_bidx(r_s_p, r_s_q)]);
  assign w_s_en  = (r_state == S_SINGLE) && !r_s_done;

  always_ff @(posedge clk) begin
    if (reset || r_state == S_LOAD) begin
      r_s_out  <= 2'd0;
      r_s_p    <= 2'd0;
      r_s_q    <= 2'd0;
      r_s_acc  <= 8'd0;
      r_s_done <= 1'b0;
      if (reset) for (int k = 0; k < 4; k++) r_s_res[k] <= 8'd0;
    end else if (w_s_en) begin
      r_s_acc <= w_s_sum;
      if (r_s_q == 2'd2) begin
        r_s_q <= 2'd0;
        if (r_s_p == 2'd2) begin
          r_s_p            <= 2'd0;
          r_s_res[r_s_out] <= w_s_sum;
          r_s_acc          <= 8'd0;
          r_s_out          <= r_s_out + 2'd1;
          if (r_s_out == 2'd3) r_s_done <= 1'b1;
        end else begin
          r_s_p <= r_s_p + 2'd1;
        end
      end else begin
        r_s_q <= r_s_q + 2'd1;
      end
    end
  end

  // ---------------- SYS3: PE p owns filter row p ----------------
  logic [1:0] r_y_out, r_y_q;
  logic [7:0] r_y_acc  [0:2];
  logic       r_y_done;
  logic [7:0] r_y_res  [0:3];
  logic [1:0] w_y_row  [0:2];
  logic [1:0] w_y_col;
  logic [7:0] w_y_next [0:2];
  logic [7:0] w_y_tot;
  logic       w_y_en;

  always_comb begin
    w_y_col = {1'b0, r_y_out[0]} + r_y_q;
    w_y_tot = 8'd0;
    for (int p = 0; p < 3; p++) begin
      w_y_row[p]  = {1'b0, r_y_out[1]} + 2'(p);
      w_y_next[p] = r_y_acc[p] + f_mul8(r_img[f_aidx(w_y_row[p], w_y_col)],
                                        r_flt[f_bidx(2'(p), r_y_q)]);
      w_y_tot     = w_y_tot + w_y_next[p];
    end
  end

  assign w_y_en = (r_state == S_SYS3) && !r_y_done;

  always_ff @(posedge clk) begin
    if (reset || r_state == S_LOAD) begin
      r_y_out  <= 2'd0;
      r_y_q    <= 2'd0;
      r_y_done <= 1'b0;
      for (int p = 0; p < 3; p++) r_y_acc[p] <= 8'd0;
      if (reset) for (int k = 0; k < 4; k++) r_y_res[k] <= 8'd0;
    end else if (w_y_en) begin
      if (r_y_q == 2'd2) begin
        // Row partial sums of the three PEs combine into one output.
        r_y_q            <= 2'd0;
        r_y_res[r_y_out] <= w_y_tot;
        r_y_out          <= r_y_out + 2'd1;
        for (int p = 0; p < 3; p++) r_y_acc[p] <= 8'd0;
        if (r_y_out == 2'd3) r_y_done <= 1'b1;
      end else begin
        r_y_q <= r_y_q + 2'd1;
        for (int p = 0; p < 3; p++) r_y_acc[p] <= w_y_next[p];
      end
    end
  end

  // ---------------- SYS2: PE j owns output column j, one row per pass ----------------
  logic       r_z_i;
  logic [1:0] r_z_p, r_z_q;
  logic [7:0] r_z_acc  [0:1];
  logic       r_z_done;
  logic [7:0] r_z_res  [0:3];
  logic [1:0] w_z_row;
  logic [1:0] w_z_col  [0:1];
  logic [7:0] w_z_next [0:1];
  logic       w_z_en;

  always_comb begin
    w_z_row = {1'b0, r_z_i} + r_z_p;
    for (int j = 0; j < 2; j++) begin
      w_z_col[j]  = 2'(j) + r_z_q;
      w_z_next[j] = r_z_acc[j] + f_mul8(r_img[f_aidx(w_z_row, w_z_col[j])],
                                        r_flt[f_bidx(r_z_p, r_z_q)]);
    end
  end

  assign w_z_en = (r_state == S_SYS2) && !r_z_done;

  always_ff @(posedge clk) begin
    if (reset || r_state == S_LOAD) begin
      r_z_i    <= 1'b0;
      r_z_p    <= 2'd0;
      r_z_q    <= 2'd0;
      r_z_done <= 1'b0;
      for (int j = 0; j < 2; j++) r_z_acc[j] <= 8'd0;
      if (reset) for (int k = 0; k < 4; k++) r_z_res[k] <= 8'd0;
    end else if (w_z_en) begin
      for (int j = 0; j < 2; j++) r_z_acc[j] <= w_z_next[j];
      if (r_z_q == 2'd2) begin
        r_z_q <= 2'd0;
        if (r_z_p == 2'd2) begin
          r_z_p                 <= 2'd0;
          r_z_res[{r_z_i, 1'b0}] <= w_z_next[0];
          r_z_res[{r_z_i, 1'b1}] <= w_z_next[1];
          for (int j = 0; j < 2; j++) r_z_acc[j] <= 8'd0;
          r_z_i                 <= ~r_z_i;
          if (r_z_i) r_z_done <= 1'b1;
        end else begin
          r_z_p <= r_z_p + 2'd1;
        end
      end else begin
        r_z_q <= r_z_q + 2'd1;
      end
    end
  end

  // ---------------- display ----------------
  logic [3:0] w_sel_idx;
  logic [7:0] w_sel_val;

  always_comb begin
    // Value that will be shown after the coming edge.
    w_sel_idx = (r_state == S_OUT) ? r_idx + 4'd1 : 4'd0;
    w_sel_val = 8'd0;
    case (w_sel_idx[3:2])
      2'd0:    w_sel_val = r_s_res[w_sel_idx[1:0]];
      2'd1:    w_sel_val = r_y_res[w_sel_idx[1:0]];
      2'd2:    w_sel_val = r_z_res[w_sel_idx[1:0]];
      default: w_sel_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= 4'd0;
      r_disp <= 8'd0;
    end else if (r_state == S_SYS2 && w_next == S_OUT) begin
      r_idx  <= 4'd0;
      r_disp <= w_sel_val;
    end else if (r_state == S_OUT && w_next == S_OUT) begin
      r_idx  <= r_idx + 4'd1;
      r_disp <= w_sel_val;
    end
  end

endmodule

// File: tb/tb_conv3x3_top.sv
module tb_conv3x3_top;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] img [0:15];
  logic [7:0] flt [0:8];
  logic [7:0] display_result;
  logic [2:0] display_current_state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [127:0] a;   // a11 in the top byte, row-major
    logic [71:0]  b;   // b11 in the top byte, row-major
    logic [31:0]  e;   // expected c11,c12,c21,c22 (c11 in the top byte)
  } vec_t;

  vec_t vecs [0:3];

  always #5 clk = ~clk;

  conv3x3_top dut (
    .clk(clk), .reset(reset), .run(run),
    .a11(img[0]),  .a12(img[1]),  .a13(img[2]),  .a14(img[3]),
    .a21(img[4]),  .a22(img[5]),  .a23(img[6]),  .a24(img[7]),
    .a31(img[8]),  .a32(img[9]),  .a33(img[10]), .a34(img[11]),
    .a41(img[12]), .a42(img[13]), .a43(img[14]), .a44(img[15]),
    .b11(flt[0]), .b12(flt[1]), .b13(flt[2]),
    .b21(flt[3]), .b22(flt[4]), .b23(flt[5]),
    .b31(flt[6]), .b32(flt[7]), .b33(flt[8]),
    .display_result(display_result),
    .display_current_state(display_current_state)
  );

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step=%0d got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    for (int k = 0; k < 16; k++) img[k] = v.a[(15-k)*8 +: 8];
    for (int k = 0; k < 9; k++)  flt[k] = v.b[(8-k)*8 +: 8];
  endtask

  task automatic scramble();
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
    for (int k = 0; k < 9; k++)  flt[k] = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
    chk("reset_state", 0, int'(display_current_state), 0);
    chk("reset_disp", 0, int'(display_result), 0);
  endtask

  // State expected after edge R+k.
  function automatic int exp_state(input int k);
    if (k == 0)   return 1;
    if (k <= 48)  return 2;
    if (k <= 72)  return 3;
    if (k <= 96)  return 4;
    if (k <= 108) return 5;
    return 6;
  endfunction

  function automatic int exp_disp(input vec_t v, input int k);
    int n;
    if (k < 97) return 0;
    n = (k <= 108) ? (k - 97) % 4 : 3;
    return int'(v.e[(3-n)*8 +: 8]);
  endfunction

  // Full run: run sampled at edge R, then observe after each edge R+k.
  // Inputs are scrambled once the operands have been latched.
  task automatic run_seq(input vec_t v, input bit hold);
    apply(v);
    run = 1'b1;
    tick();
    for (int k = 0; k <= 112; k++) begin
      chk("state", k, int'(display_current_state), exp_state(k));
      chk("disp", k, int'(display_result), exp_disp(v, k));
      if (k == 1) scramble();
      if (k == 4 && !hold) run = 1'b0;
      tick();
    end
    run = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) img[k] = 8'd0;
    for (int k = 0; k < 9; k++)  flt[k] = 8'd0;

    vecs[0].a = {8'd3, 8'd1, 8'd6, 8'd5, 8'd7, 8'd5, 8'd2, 8'd7,
                 8'd7, 8'd10, 8'd8, 8'd9, 8'd1, 8'd3, 8'd2, 8'd10};
    vecs[0].b = {8'd3, 8'd1, 8'd4, 8'd0, 8'd5, 8'd1, 8'd0, 8'd1, 8'd5};
    vecs[0].e = {8'd110, 8'd101, 8'd110, 8'd121};

    vecs[1].a = {8'd72, 8'd58, 8'd36, 8'd24, 8'd254, 8'd210, 8'd159, 8'd73,
                 8'd89, 8'd72, 8'd205, 8'd101, 8'd220, 8'd9, 8'd87, 8'd172};
    vecs[1].b = {8'd201, 8'd170, 8'd24, 8'd59, 8'd109, 8'd187, 8'd80, 8'd141, 8'd210};
    vecs[1].e = {8'd248, 8'd3, 8'd137, 8'd121};

    vecs[2].a = {8'd58, 8'd72, 8'd36, 8'd24, 8'd254, 8'd210, 8'd159, 8'd73,
                 8'd89, 8'd72, 8'd205, 8'd101, 8'd220, 8'd9, 8'd87, 8'd172};
    vecs[2].b = vecs[1].b;
    vecs[2].e = {8'd50, 8'd127, 8'd137, 8'd121};

    vecs[3].a = {8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3,
                 8'd3, 8'd0, 8'd1, 8'd2, 8'd2, 8'd3, 8'd0, 8'd1};
    vecs[3].b = {8'd2, 8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd2};
    vecs[3].e = {8'd11, 8'd12, 8'd10, 8'd11};

    // Reset state and idling without run.
    do_reset();
    apply(vecs[0]);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_state", k, int'(display_current_state), 0);
      chk("idle_disp", k, int'(display_result), 0);
    end

    // Table-driven full runs; odd entries keep run high throughout.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_seq(vecs[i], bit'(i % 2));
    end

    // Reset in the middle of SYS3, then a fresh run with other data.
    do_reset();
    apply(vecs[1]);
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 1; k <= 60; k++) tick();
    chk("mid_sys3_state", 60, int'(display_current_state), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_state", 0, int'(display_current_state), 0);
    chk("midrst_disp", 0, int'(display_result), 0);
    tick();
    chk("midrst_idle", 1, int'(display_current_state), 0);
    run_seq(vecs[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
